// File: rtl/mlp_pkg.sv
// mlp_pkg: shared word type, layer sizes, config address map
// and controller state encoding for the MLP controller slice.
package mlp_pkg;

    localparam int NBits = 16;

    localparam int NIn  = 6;
    localparam int NHid = 16;
    localparam int NOut = 3;

    localparam int W1Base = 0;
    localparam int B1Base = 96;
    localparam int W2Base = 112;
    localparam int B2Base = 160;
    localparam int NCfg   = 163;

    typedef logic [NBits-1:0] T;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/mlp_cfg_regs.sv
// mlp_cfg_regs: flat weight/bias store written by config address,
// fanned out to the layer-shaped datapath buses.
module mlp_cfg_regs
    import mlp_pkg::*;
#(
    parameter int NBits = mlp_pkg::NBits
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 we_i,
    input  logic [7:0]                           addr_i,
    input  logic [NBits-1:0]                     data_i,
    output logic                                 addr_ok_o,
    output logic [NIn-1:0][NHid-1:0][NBits-1:0]  w1_o,
    output logic [NHid-1:0][NBits-1:0]           b1_o,
    output logic [NHid-1:0][NOut-1:0][NBits-1:0] w2_o,
    output logic [NOut-1:0][NBits-1:0]           b2_o
);

    logic [NBits-1:0] regs_q [NCfg];

    assign addr_ok_o = (addr_i < 8'(NCfg));

    // One word per config address; writes are pre-qualified by the controller
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NCfg; k++) begin
                regs_q[k] <= '0;
            end
        end else if (we_i && addr_ok_o) begin
            regs_q[addr_i] <= data_i;
        end
    end

    for (genvar i = 0; i < NIn; i++) begin : g_w1
        for (genvar j = 0; j < NHid; j++) begin : g_w1c
            assign w1_o[i][j] = regs_q[W1Base + i*NHid + j];
        end
    end

    for (genvar j = 0; j < NHid; j++) begin : g_b1
        assign b1_o[j] = regs_q[B1Base + j];
    end

    for (genvar i = 0; i < NHid; i++) begin : g_w2
        for (genvar j = 0; j < NOut; j++) begin : g_w2c
            assign w2_o[i][j] = regs_q[W2Base + i*NOut + j];
        end
    end

    for (genvar j = 0; j < NOut; j++) begin : g_b2
        assign b2_o[j] = regs_q[B2Base + j];
    end

endmodule

// File: rtl/mlp_ctrl.sv
// mlp_ctrl: config port, input/output handshake and latency
// sequencing around an external fixed-latency MLP datapath.
module mlp_ctrl
    import mlp_pkg::*;
#(
    parameter int NBits   = mlp_pkg::NBits,
    parameter int Latency = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 cfg_we_i,
    input  logic [7:0]                           cfg_addr_i,
    input  logic [NBits-1:0]                     cfg_data_i,
    output logic                                 cfg_err_o,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [NIn-1:0][NBits-1:0]            in_data_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [NOut-1:0][NBits-1:0]           out_data_o,
    output logic                                 busy_o,
    output logic [NIn-1:0][NBits-1:0]            mlp_din_o,
    output logic [NIn-1:0][NHid-1:0][NBits-1:0]  mlp_w1_o,
    output logic [NHid-1:0][NBits-1:0]           mlp_b1_o,
    output logic [NHid-1:0][NOut-1:0][NBits-1:0] mlp_w2_o,
    output logic [NOut-1:0][NBits-1:0]           mlp_b2_o,
    input  logic [NOut-1:0][NBits-1:0]           mlp_dout_i
);

    localparam int CW = (Latency < 1) ? 1 : $clog2(Latency + 1);
    localparam logic [CW-1:0] LastCnt = CW'(Latency);

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [NIn-1:0][NBits-1:0]  din_q, din_d;
    logic [NOut-1:0][NBits-1:0] dout_q, dout_d;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;
    logic                      addr_ok;
    logic                      cfg_wr;
    logic                      accept;

    // Config writes win over input acceptance and only land while idle
    assign in_ready_o  = (state_q == IDLE) && !cfg_we_i;
    assign accept      = in_valid_i && in_ready_o;
    assign cfg_wr      = cfg_we_i && (state_q == IDLE) && addr_ok;
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = valid_q;
    assign out_data_o  = dout_q;
    assign mlp_din_o   = din_q;
    assign cfg_err_o   = err_q;

    mlp_cfg_regs #(
        .NBits(NBits)
    ) u_regs (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (cfg_wr),
        .addr_i   (cfg_addr_i),
        .data_i   (cfg_data_i),
        .addr_ok_o(addr_ok),
        .w1_o     (mlp_w1_o),
        .b1_o     (mlp_b1_o),
        .w2_o     (mlp_w2_o),
        .b2_o     (mlp_b2_o)
    );

    // Next state: latch input, count datapath latency, hold result until taken
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        err_d   = cfg_we_i && !cfg_wr;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    din_d   = in_data_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LastCnt) begin
                    dout_d  = mlp_dout_i;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous clear of all in-flight data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/mlp_ctrl.md
MLP_CTRL -- requirements
Module: mlp_ctrl

Interface
REQ-001 SHALL have parameter NBits, default 16, word width of all data, weights and biases.
REQ-002 SHALL have parameter Latency, default 3, clock edges from stable mlp_din_o to valid mlp_dout_i.
REQ-003 SHALL have ports:
- clk_i  in  1  single clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- cfg_we_i  in  1  config write strobe.
- cfg_addr_i  in  8  config word address.
- cfg_data_i  in  NBits  config write data.
- cfg_err_o  out  1  one-cycle pulse on a rejected write.
- in_valid_i  in  1  input vector valid.
- in_ready_o  out  1  input vector accepted when high with in_valid_i.
- in_data_i  in  6 x NBits  input feature vector.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result consumed when high with out_valid_o.
- out_data_o  out  3 x NBits  result vector.
- busy_o  out  1  high in RUN or DONE.
- mlp_din_o  out  6 x NBits  datapath input.
- mlp_w1_o  out  6x16 x NBits  layer-1 weights.
- mlp_b1_o  out  16 x NBits  layer-1 biases.
- mlp_w2_o  out  16x3 x NBits  layer-2 weights.
- mlp_b2_o  out  3 x NBits  layer-2 biases.
- mlp_dout_i  in  3 x NBits  datapath result.

Function
REQ-004 SHALL use config address map: 0-95 W1[i][j] at i*16+j; 96-111 B1[j] at 96+j; 112-159 W2[i][j] at 112+i*3+j; 160-162 B2[j] at 160+j.
REQ-005 SHALL use FSM states IDLE, RUN, DONE.
REQ-006 SHALL write cfg_data_i to the addressed register on a clock edge with cfg_we_i=1, state IDLE and address <= 162.
REQ-007 SHALL not write on cfg_we_i=1 with address >= 163 or state not IDLE; cfg_err_o is high for exactly the next cycle.
REQ-008 SHALL drive in_ready_o = (state==IDLE) && !cfg_we_i, so a config write takes priority over input acceptance.
REQ-009 On acceptance, SHALL register in_data_i onto mlp_din_o, clear the counter to 0 and enter RUN.
REQ-010 SHALL hold mlp_din_o and all weight and bias outputs stable in RUN and DONE.
REQ-011 In RUN, SHALL increment the counter each cycle; with counter == Latency, SHALL capture mlp_dout_i into out_data_o at that edge and enter DONE.
REQ-012 Acceptance to out_valid_o high SHALL be Latency+1 cycles (4 at default).
REQ-013 SHALL hold out_valid_o=1 and out_data_o stable in DONE until out_ready_i=1, then go to IDLE.
REQ-014 SHALL keep in_ready_o=0 in the cycle DONE exits, with no back-to-back acceptance.
REQ-015 SHALL keep out_data_o holding the last result after DONE exits.
REQ-016 SHALL keep the counter width ceil(log2(Latency+1)) bits, never wrapping.

Reset
REQ-017 On rst_i=1, SHALL asynchronously go to IDLE with counter, mlp_din_o, all weight and bias registers, out_data_o, out_valid_o and cfg_err_o at 0.
REQ-018 On reset mid-RUN or mid-DONE, SHALL discard the in-flight result and raise no out_valid_o after reset release.
REQ-019 After rst_i deasserts, SHALL accept a config write or input from the first rising edge.

Structure
REQ-020 SHALL take NBits, word type T, dimensions 6/16/3, address-map base constants and state enum from shared package mlp_pkg.
REQ-021 SHALL hold the weight and bias storage plus address decode in one sub-module mlp_cfg_regs; FSM and handshake stay in mlp_ctrl.

Verification
REQ-022 Bench SHALL check: write 0x0100 to addr 0, 96 and 160 -> mlp_w1_o[0][0], mlp_b1_o[0] and mlp_b2_o[0] read 0x0100; other entries 0.
REQ-023 Bench SHALL check: write to addr 163 in IDLE -> no register change, cfg_err_o high one cycle.
REQ-024 Bench SHALL check: accept input at cycle t, out_ready_i=1 -> out_valid_o rises at t+4 equal to mlp_dout_i sampled at t+3, IDLE at t+5.
REQ-025 Bench SHALL check: cfg_we_i to addr 5 during RUN -> write dropped, cfg_err_o pulses, result unchanged.
REQ-026 Bench SHALL check: cfg_we_i and in_valid_i together in IDLE -> write applied, in_ready_o=0, input accepted next cycle.
REQ-027 Bench SHALL check: out_ready_i low 10 cycles in DONE -> out_data_o stable, in_ready_o=0; rst_i pulse at cycle 2 of RUN -> IDLE, outputs 0, no out_valid_o.
